// File: rtl/bp_bht_pkg.sv
// Shared constants and opcode decode for the branch history table predictor.
// Optional gshare indexing is enabled with the BP_GSHARE_EN macro (see bp_bht.sv).
package bp_bht_pkg;

    localparam logic JUMP     = 1'b1;
    localparam logic NOT_JUMP = 1'b0;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        KIND_OTHER,
        KIND_JAL,
        KIND_JALR,
        KIND_BRANCH
    } inst_kind_e;

    function automatic inst_kind_e decode_kind(input logic [6:0] opcode);
        inst_kind_e kind;
        case (opcode)
            OP_JAL:    kind = KIND_JAL;
            OP_JALR:   kind = KIND_JALR;
            OP_BRANCH: kind = KIND_BRANCH;
            default:   kind = KIND_OTHER;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/bp_bht_if.sv
// Fetch-side (iCache -> INF) and commit-side (ROB) signals of the branch predictor.
// master = iCache/ROB/INF environment, slave = bp_bht.
interface bp_bht_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int IDX_W  = 8
);
    logic              iMC_en;
    logic [INST_W-1:0] iMC_inst;
    logic [ADDR_W-1:0] iMC_pc;
    logic              oINF_pd;
    logic [ADDR_W-1:0] oINF_target;
    logic [IDX_W-1:0]  oINF_idx;
    logic              iROB_commit_en;
    logic [IDX_W-1:0]  iROB_idx;
    logic              iROB_taken;

    modport master (
        output iMC_en, iMC_inst, iMC_pc,
        output iROB_commit_en, iROB_idx, iROB_taken,
        input  oINF_pd, oINF_target, oINF_idx
    );

    modport slave (
        input  iMC_en, iMC_inst, iMC_pc,
        input  iROB_commit_en, iROB_idx, iROB_taken,
        output oINF_pd, oINF_target, oINF_idx
    );
endinterface

// File: rtl/bp_sat_cnt_tbl.sv
// Table of saturating counters: one combinational read port, one clocked
// saturating update port. Counters reset to weakly not-taken.
module bp_sat_cnt_tbl #(
    parameter int IDX_W = 8,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);
    localparam int               DEPTH    = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] cnt_arr [DEPTH];
    logic [CNT_W-1:0] wr_cur;
    logic [CNT_W-1:0] wr_next;

    assign rd_cnt = cnt_arr[rd_idx];
    assign wr_cur = cnt_arr[wr_idx];

    always_comb begin
        wr_next = wr_cur;
        if (wr_taken) begin
            if (wr_cur != CNT_MAX) wr_next = wr_cur + 1'b1;
        end else begin
            if (wr_cur != '0) wr_next = wr_cur - 1'b1;
        end
    end

    // Each entry is its own register so the whole table can clear on async reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= CNT_INIT;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    cnt_reg <= wr_next;
                end
            end
            assign cnt_arr[gi] = cnt_reg;
        end
    endgenerate

endmodule

// File: rtl/bp_bht.sv
// Fetch-stage branch predictor: decodes the fetched instruction, predicts via a
// saturating-counter table trained by ROB commits. Macro BP_GSHARE_EN adds gshare hashing.
module bp_bht
    import bp_bht_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int IDX_W  = 8,
    parameter int CNT_W  = 2,
    parameter int GHR_W  = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    rdy,
    bp_bht_if.slave bus
);
    localparam int HIST_W = (GHR_W < IDX_W) ? GHR_W : IDX_W;

    logic [6:0]        opcode;
    inst_kind_e        kind;
    logic [20:0]       j_imm_raw;
    logic [12:0]       b_imm_raw;
    logic [ADDR_W-1:0] j_imm;
    logic [ADDR_W-1:0] b_imm;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] jal_target;
    logic [ADDR_W-1:0] br_target;
    logic [IDX_W-1:0]  pc_idx;
    logic [HIST_W-1:0] hist;
    logic [IDX_W-1:0]  fetch_idx;
    logic [CNT_W-1:0]  rd_cnt;
    logic              train_en;
    logic              pd_next;
    logic [ADDR_W-1:0] target_next;
    logic [IDX_W-1:0]  idx_next;

    assign opcode    = bus.iMC_inst[6:0];
    assign kind      = decode_kind(opcode);
    assign j_imm_raw = {bus.iMC_inst[31], bus.iMC_inst[19:12], bus.iMC_inst[20],
                        bus.iMC_inst[30:21], 1'b0};
    assign b_imm_raw = {bus.iMC_inst[31], bus.iMC_inst[7], bus.iMC_inst[30:25],
                        bus.iMC_inst[11:8], 1'b0};
    assign j_imm     = {{(ADDR_W - 21){j_imm_raw[20]}}, j_imm_raw};
    assign b_imm     = {{(ADDR_W - 13){b_imm_raw[12]}}, b_imm_raw};

    assign pc_plus4   = bus.iMC_pc + ADDR_W'(4);
    assign jal_target = bus.iMC_pc + j_imm;
    assign br_target  = bus.iMC_pc + b_imm;

    assign train_en = rdy && bus.iROB_commit_en;
    assign pc_idx   = bus.iMC_pc[IDX_W+1:2];

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] ghr_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_reg <= '0;
        end else if (train_en) begin
            ghr_reg <= HIST_W'({ghr_reg, bus.iROB_taken});
        end
    end

    assign hist = ghr_reg;
`else
    // Without gshare the history term is a constant zero, leaving the plain PC slice.
    assign hist = '0;
`endif

    assign fetch_idx = pc_idx ^ IDX_W'(hist);

    // Training uses the index that travelled with the branch, not a fresh hash.
    bp_sat_cnt_tbl #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_tbl (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (fetch_idx),
        .rd_cnt   (rd_cnt),
        .wr_en    (train_en),
        .wr_idx   (bus.iROB_idx),
        .wr_taken (bus.iROB_taken)
    );

    always_comb begin
        pd_next     = NOT_JUMP;
        target_next = pc_plus4;
        idx_next    = fetch_idx;
        if (rdy && bus.iMC_en) begin
            case (kind)
                KIND_JAL: begin
                    pd_next     = JUMP;
                    target_next = jal_target;
                end
                KIND_BRANCH: begin
                    if (rd_cnt[CNT_W-1]) begin
                        pd_next     = JUMP;
                        target_next = br_target;
                    end
                end
                default: begin
                    pd_next     = NOT_JUMP;
                    target_next = pc_plus4;
                end
            endcase
        end
        // Outputs are forced quiet for as long as reset is held.
        if (!rst) begin
            pd_next     = NOT_JUMP;
            target_next = '0;
            idx_next    = '0;
        end
    end

    assign bus.oINF_pd     = pd_next;
    assign bus.oINF_target = target_next;
    assign bus.oINF_idx    = idx_next;

endmodule
